// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the M-stage data-bus controller:
// access-size decode, alignment check, byte enables and store lane replication.
package dm_pkg;

    localparam logic [2:0] DM_W  = 3'd0;
    localparam logic [2:0] DM_BU = 3'd1;
    localparam logic [2:0] DM_B  = 3'd2;
    localparam logic [2:0] DM_HU = 3'd3;
    localparam logic [2:0] DM_H  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dm_state_t;

    function automatic int dm_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    // Encodings 5..7 fall through to word access in every helper.
    function automatic logic dm_misaligned(input logic [2:0] op, input logic [1:0] lo);
        logic r;
        case (op)
            DM_BU, DM_B: r = 1'b0;
            DM_HU, DM_H: r = lo[0];
            default:     r = (lo != 2'b00);
        endcase
        return r;
    endfunction

    function automatic logic [3:0] dm_be(input logic [2:0] op, input logic [1:0] lo);
        logic [3:0] r;
        case (op)
            DM_BU, DM_B: r = 4'b0001 << lo;
            DM_HU, DM_H: r = lo[1] ? 4'b1100 : 4'b0011;
            default:     r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] dm_wdata(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] r;
        case (op)
            DM_BU, DM_B: r = {4{wd[7:0]}};
            DM_HU, DM_H: r = {2{wd[15:0]}};
            default:     r = wd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load-data lane select and sign/zero extension for the word returned by the bus.
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte/half, then extend according to the op.
    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        case (i_op)
            DM_BU:   o_data = {24'h000000, w_byte};
            DM_B:    o_data = {{24{w_byte[7]}}, w_byte};
            DM_HU:   o_data = {16'h0000, w_half};
            DM_H:    o_data = {{16{w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/dm_bus_ctrl.sv
// M-stage load/store controller: alignment check, bus request issue, wait/timeout
// handling, pipeline stall and extended load result.
module dm_bus_ctrl
    import dm_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_we,
    input  logic [2:0]  m_op,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic        m_kill,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        adel,
    output logic        ades,
    output logic        bus_timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int             CW       = dm_cnt_width(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    dm_state_t     r_state;
    dm_state_t     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_op;
    logic [1:0]    r_addr_lo;
    logic          r_killed;
    logic          w_accept;
    logic          w_req_ack;
    logic          w_req_tmo;
    logic [31:0]   w_ext;

    dm_load_ext u_load_ext (
        .i_word    (bus_rdata),
        .i_op      (r_op),
        .i_addr_lo (r_addr_lo),
        .o_data    (w_ext)
    );

    // Next state plus the combinational stall and address-error outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_req_ack   = 1'b0;
        w_req_tmo   = 1'b0;
        stall       = 1'b0;
        adel        = 1'b0;
        ades        = 1'b0;
        case (r_state)
            IDLE: begin
                if (m_valid && !m_kill && !reset) begin
                    if (dm_misaligned(m_op, m_addr[1:0])) begin
                        adel = !m_we;
                        ades = m_we;
                    end else begin
                        w_accept    = 1'b1;
                        stall       = 1'b1;
                        w_state_nxt = REQ;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                stall = 1'b1;
                // An ack on the last allowed cycle still completes normally.
                if (bus_ack) begin
                    w_req_ack   = 1'b1;
                    w_state_nxt = DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_req_tmo   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, request latch, bus registers and completion pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op        <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_killed    <= 1'b0;
            rdata       <= 32'h0000_0000;
            rdata_valid <= 1'b0;
            bus_timeout <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'h0000_0000;
            bus_be      <= 4'h0;
            bus_wdata   <= 32'h0000_0000;
        end else begin
            r_state     <= w_state_nxt;
            rdata_valid <= 1'b0;
            bus_timeout <= 1'b0;
            if (w_accept) begin
                r_cnt     <= '0;
                r_op      <= m_op;
                r_addr_lo <= m_addr[1:0];
                r_killed  <= 1'b0;
                bus_req   <= 1'b1;
                bus_we    <= m_we;
                bus_addr  <= {m_addr[31:2], 2'b00};
                bus_be    <= dm_be(m_op, m_addr[1:0]);
                bus_wdata <= dm_wdata(m_op, m_wdata);
            end else if (r_state == REQ) begin
                r_cnt <= r_cnt + CW'(1);
                if (m_kill) begin
                    r_killed <= 1'b1;
                end
                if (w_req_ack) begin
                    bus_req     <= 1'b0;
                    rdata       <= w_ext;
                    rdata_valid <= !bus_we && !r_killed && !m_kill;
                end else if (w_req_tmo) begin
                    bus_req     <= 1'b0;
                    rdata       <= 32'h0000_0000;
                    bus_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_bus_ctrl.sv
// Randomized self-checking bench for dm_bus_ctrl against an arithmetic access model.
module tb_dm_bus_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid, m_we, m_kill, bus_ack;
    logic [2:0]  m_op;
    logic [31:0] m_addr, m_wdata, bus_rdata;
    logic        stall, rdata_valid, adel, ades, bus_timeout, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    int checks = 0;
    int errors = 0;

    dm_bus_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_we(m_we), .m_op(m_op),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_kill(m_kill), .stall(stall),
        .rdata(rdata), .rdata_valid(rdata_valid), .adel(adel), .ades(ades),
        .bus_timeout(bus_timeout), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    function automatic int sz(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 1;
        if (op == 3'd3 || op == 3'd4) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] op, input logic [31:0] addr);
        int s, off, m;
        s = sz(op);
        off = (int'(addr[1:0]) / s) * s;
        m = (1 << s) - 1;
        return 4'(m << off);
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] op, input logic [31:0] w);
        if (sz(op) == 1) return {24'h000000, w[7:0]} * 32'h0101_0101;
        if (sz(op) == 2) return {16'h0000, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] word);
        logic [31:0] f;
        int s, off;
        s = sz(op);
        off = (int'(addr[1:0]) / s) * s;
        f = word >> (8 * off);
        if (s == 1) f = f & 32'h0000_00FF;
        else if (s == 2) f = f & 32'h0000_FFFF;
        if (op == 3'd2 && f[7]) f = f | 32'hFFFF_FF00;
        if (op == 3'd4 && f[15]) f = f | 32'hFFFF_0000;
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access from the accept cycle to DONE; returns at DONE+1 (+1ns).
    task automatic run_access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rword,
                              input int waits, input int kill_at);
        bit mis, tmo, killed, exp_v;
        int nreq;
        mis = (int'(addr[1:0]) % sz(op)) != 0;
        m_valid = 1'b1; m_we = we; m_op = op; m_addr = addr; m_wdata = wdata;
        m_kill = 1'b0; bus_ack = 1'b0; bus_rdata = $urandom;
        #1;
        checks++;
        if (stall !== !mis || adel !== (mis && !we) || ades !== (mis && we) || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL accept a=%h op=%0d we=%b: stall=%b adel=%b ades=%b req=%b, want stall=%b adel=%b ades=%b req=0",
                     addr, op, we, stall, adel, ades, bus_req, !mis, mis && !we, mis && we);
        end
        step();
        if (mis) begin
            m_valid = 1'b0;
            #1;
            checks++;
            if (bus_req !== 1'b0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL misaligned_no_bus a=%h: req=%b stall=%b, want 0 0", addr, bus_req, stall);
            end
            step();
            return;
        end
        tmo = waits >= TMO;
        nreq = tmo ? TMO : waits + 1;
        killed = (kill_at >= 0) && (kill_at < nreq);
        for (int i = 0; i < nreq; i++) begin
            bus_ack = (i == waits);
            m_kill = (i == kill_at);
            bus_rdata = (i == waits) ? rword : $urandom;
            #1;
            checks++;
            if (bus_req !== 1'b1 || stall !== 1'b1 || bus_we !== we ||
                bus_addr !== {addr[31:2], 2'b00} || bus_be !== exp_be(op, addr) ||
                (we && bus_wdata !== exp_wd(op, wdata)) || rdata_valid !== 1'b0 || bus_timeout !== 1'b0) begin
                errors++;
                $display("FAIL req_cycle%0d a=%h op=%0d: req=%b stall=%b we=%b addr=%h be=%b wd=%h rv=%b to=%b, want 1 1 %b %h %b %h 0 0",
                         i, addr, op, bus_req, stall, bus_we, bus_addr, bus_be, bus_wdata, rdata_valid,
                         bus_timeout, we, {addr[31:2], 2'b00}, exp_be(op, addr), exp_wd(op, wdata));
            end
            step();
        end
        m_kill = 1'b0;
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        exp_v = !we && !tmo && !killed;
        #1;
        checks++;
        if (stall !== 1'b0 || bus_req !== 1'b0 || rdata_valid !== exp_v || bus_timeout !== tmo) begin
            errors++;
            $display("FAIL done a=%h op=%0d waits=%0d kill=%0d: stall=%b req=%b rv=%b to=%b, want 0 0 %b %b",
                     addr, op, waits, kill_at, stall, bus_req, rdata_valid, bus_timeout, exp_v, tmo);
        end
        if (exp_v || tmo) begin
            checks++;
            if (rdata !== (tmo ? 32'h0 : exp_rd(op, addr, rword))) begin
                errors++;
                $display("FAIL rdata a=%h op=%0d word=%h: got %h, want %h", addr, op, rword, rdata,
                         tmo ? 32'h0 : exp_rd(op, addr, rword));
            end
        end
        step();
        m_valid = 1'b0;
        bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; m_valid = 1'b1; m_we = 1'b0; m_op = 3'd0; m_addr = 32'h3;
        m_wdata = 32'h0; m_kill = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
        step(); step();
        checks++;
        if ({stall, rdata_valid, adel, ades, bus_timeout, bus_req, bus_we} !== 7'b0 ||
            rdata !== 32'h0 || bus_addr !== 32'h0 || bus_be !== 4'h0 || bus_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: stall=%b rv=%b adel=%b ades=%b to=%b req=%b rdata=%h be=%b, want all 0",
                     stall, rdata_valid, adel, ades, bus_timeout, bus_req, rdata, bus_be);
        end
        m_valid = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_directed();
        run_access(1'b0, 3'd2, 32'h0000_0013, 32'h0, 32'h80FF_1234, 2, -1);
        run_access(1'b1, 3'd3, 32'h0000_0022, 32'h0000_BEEF, 32'h0, 0, -1);
        run_access(1'b0, 3'd4, 32'h0000_1002, 32'h0, 32'h8001_7FFF, 1, -1);
        run_access(1'b0, 3'd6, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 0, -1);
    endtask

    task automatic test_misaligned();
        run_access(1'b0, 3'd0, 32'h0000_0006, 32'h0, 32'h0, 0, -1);
        run_access(1'b1, 3'd3, 32'h0000_0001, 32'h0, 32'h0, 0, -1);
        run_access(1'b1, 3'd0, 32'h0000_0103, 32'h0, 32'h0, 0, -1);
        run_access(1'b0, 3'd4, 32'h0000_0fff, 32'h0, 32'h0, 0, -1);
    endtask

    task automatic test_timeout();
        run_access(1'b0, 3'd0, 32'h0000_0100, 32'h0, 32'h1234_5678, 100, -1);
        run_access(1'b0, 3'd1, 32'h0000_0101, 32'h0, 32'h1234_5678, TMO - 1, -1);
        run_access(1'b1, 3'd0, 32'h0000_0104, 32'hA5A5_5A5A, 32'h0, TMO, -1);
    endtask

    task automatic test_kill();
        run_access(1'b0, 3'd0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1, 0);
        run_access(1'b0, 3'd2, 32'h0000_0041, 32'h0, 32'h0000_8000, 2, 2);
        m_valid = 1'b1; m_kill = 1'b1; m_we = 1'b0; m_op = 3'd0; m_addr = 32'h80;
        #1;
        checks++;
        if (stall !== 1'b0 || adel !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle_stall: stall=%b adel=%b, want 0 0", stall, adel);
        end
        step();
        m_valid = 1'b0; m_kill = 1'b0; bus_ack = 1'b1;
        #1;
        checks++;
        if (bus_req !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle_req: req=%b, want 0", bus_req);
        end
        step();
        bus_ack = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || rdata_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: req=%b rv=%b stall=%b, want 0 0 0", bus_req, rdata_valid, stall);
        end
        step();
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 3'd1, 32'h0000_0203, 32'h0000_00C3, 32'h0, 0, -1);
        run_access(1'b0, 3'd3, 32'h0000_0202, 32'h0, 32'hFEDC_BA98, 0, -1);
        run_access(1'b0, 3'd2, 32'h0000_0201, 32'h0, 32'h0000_9100, 1, -1);
    endtask

    task automatic test_reset_mid_req();
        run_access(1'b0, 3'd0, 32'h0000_0300, 32'h0, 32'h0, 0, -1);
        m_valid = 1'b1; m_we = 1'b0; m_op = 3'd0; m_addr = 32'h0000_0310;
        #1;
        step();
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({stall, rdata_valid, adel, ades, bus_timeout, bus_req, bus_we} !== 7'b0 ||
            rdata !== 32'h0 || bus_addr !== 32'h0 || bus_be !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid_req: stall=%b req=%b rv=%b to=%b addr=%h be=%b rdata=%h, want all 0",
                     stall, bus_req, rdata_valid, bus_timeout, bus_addr, bus_be, rdata);
        end
        step();
        reset = 1'b0;
        m_valid = 1'b0;
        step();
        run_access(1'b0, 3'd3, 32'h0000_0002, 32'h0, 32'h8001_5A5A, 1, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            logic we;
            logic [2:0] op;
            int kill_at;
            we = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            kill_at = (!we && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO)) : -1;
            run_access(we, op, $urandom, $urandom, $urandom, int'($urandom_range(0, TMO + 1)), kill_at);
            if ($urandom_range(0, 2) == 0) step();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_misaligned();
        test_timeout();
        test_kill();
        test_back_to_back();
        test_reset_mid_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
